// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl: collects hex digit strobes into a shift buffer and hands the entry downstream over valid/ready; ports: clk, rst (async), pulse/hex/del/enter/clr event strobes, out_ready/out_data/out_valid handshake, disp_data/count/busy/overflow status
module digit_entry_ctrl #(
  parameter int DIGITS  = 8,
  parameter int TIMEOUT = 500_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pulse,
  input  logic [3:0]                  hex,
  input  logic                        del,
  input  logic                        enter,
  input  logic                        clr,
  input  logic                        out_ready,
  output logic [4*DIGITS-1:0]         out_data,
  output logic                        out_valid,
  output logic [4*DIGITS-1:0]         disp_data,
  output logic [$clog2(DIGITS+1)-1:0] count,
  output logic                        busy,
  output logic                        overflow
);
  localparam int CW = $clog2(DIGITS+1);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT+1) : 1;
  localparam logic [TW-1:0] TLIM = TIMEOUT > 0 ? TW'(TIMEOUT-1) : '0;
  typedef enum logic [1:0] {EMPTY, ENTRY, FULL, COMMIT} state_t;
  state_t state, n_state;
  logic [4*DIGITS-1:0] buffer, n_buf, n_out;
  logic [CW-1:0] n_count;
  logic [TW-1:0] timer, n_timer;
  logic n_ovf, timeout;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= EMPTY;
      buffer   <= '0;
      count    <= '0;
      out_data <= '0;
      overflow <= 1'b0;
      timer    <= '0;
    end else begin
      state    <= n_state;
      buffer   <= n_buf;
      count    <= n_count;
      out_data <= n_out;
      overflow <= n_ovf;
      timer    <= n_timer;
    end
  // auto-clear fires only on an otherwise idle cycle of a partial/full entry
  assign timeout = TIMEOUT != 0 && (state == ENTRY || state == FULL) &&
                   !(pulse | del | enter | clr) && timer == TLIM;
  always_comb begin
    n_state = state;
    n_buf   = buffer;
    n_count = count;
    n_out   = out_data;
    n_ovf   = 1'b0;
    n_timer = '0;
    if (state == COMMIT) begin
      if (out_ready) begin
        n_state = EMPTY;
        n_buf   = '0;
        n_count = '0;
      end
    end else if (clr || timeout) begin
      n_state = EMPTY;
      n_buf   = '0;
      n_count = '0;
    end else if (enter) begin
      if (state != EMPTY) begin
        n_out   = buffer;
        n_state = COMMIT;
      end
    end else if (del) begin
      if (state != EMPTY) begin
        n_buf   = buffer >> 4;
        n_count = count - 1'b1;
        n_state = count == CW'(1) ? EMPTY : ENTRY;
      end
    end else if (pulse) begin
      if (state == FULL) n_ovf = 1'b1;
      else begin
        n_buf   = {buffer[4*DIGITS-5:0], hex};
        n_count = count + 1'b1;
        n_state = count == CW'(DIGITS-1) ? FULL : ENTRY;
      end
    end else if (state != EMPTY && TIMEOUT != 0) n_timer = timer + 1'b1;
  end
  assign disp_data = buffer;
  assign out_valid = state == COMMIT;
  assign busy      = state == COMMIT;
endmodule
